// File: rtl/cos_sweep_driver.sv
// ---------------------------------------------------------------------------
// cos_sweep_driver
//
// Sweeps a cosine core over an arithmetic sequence of angles. A request
// (go) latches the first angle, the signed step and the number of angles;
// the driver then runs one start/ready handshake with the core per angle,
// hands each result to a consumer with a valid/ack handshake and pulses
// done at the end of the sweep. A per-phase watchdog aborts the sweep if
// the core fails to move its ready flag within TIMEOUT cycles.
//
// Handshakes:
//   core side  : core_start is held high until the core has first dropped
//                core_ready (ARM) and then raised it (WAIT). core_start is
//                low for at least one cycle between conversions.
//   result side: res_valid/res_angle/res_cos are held stable until the
//                consumer asserts res_ack in a cycle with res_valid=1; an
//                ack in any other cycle has no effect.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   go                      sweep request, sampled only when idle
//   angle_first/_step/count sweep description, sampled with go
//   core_start, core_angle  request and operand to the cosine core
//   core_ready, core_cos    result flag and result from the cosine core
//   res_valid/_angle/_cos   result output, res_ack accepts it
//   busy                    high whenever not idle
//   done                    one-cycle pulse at sweep end (normal or aborted)
//   timeout_err             sticky watchdog error, cleared by reset or go
//   state_dbg_o             current FSM state, for observation only
// ---------------------------------------------------------------------------
module cos_sweep_driver #(
    parameter int W         = 24,
    parameter int FXP_SHIFT = 10,
    parameter int TIMEOUT   = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         go,
    input  logic [W-1:0] angle_first,
    input  logic [W-1:0] angle_step,
    input  logic [7:0]   count,
    output logic         core_start,
    output logic [W-1:0] core_angle,
    input  logic         core_ready,
    input  logic [W-1:0] core_cos,
    output logic         res_valid,
    output logic [W-1:0] res_angle,
    output logic [W-1:0] res_cos,
    input  logic         res_ack,
    output logic         busy,
    output logic         done,
    output logic         timeout_err,
    output logic [2:0]   state_dbg_o
);

    // The fixed-point format only matters to the core; the driver treats
    // angles as plain W-bit words. Reject formats that cannot fit.
    if (FXP_SHIFT < 0 || FXP_SHIFT >= W) begin : g_fxp_shift_invalid
        $error("cos_sweep_driver: FXP_SHIFT must lie in [0, W-1]");
    end

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_WAIT = 3'd2,
        S_CAPT = 3'd3,
        S_OUT  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   core_angle_q, core_angle_d;
    logic [W-1:0]   step_q, step_d;
    logic [7:0]     remain_q, remain_d;
    logic [W-1:0]   res_angle_q, res_angle_d;
    logic [W-1:0]   res_cos_q, res_cos_d;
    logic           timeout_err_q, timeout_err_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           cnt_last;

    // Last permitted cycle of the current ARM/WAIT phase.
    assign cnt_last = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            core_angle_q  <= '0;
            step_q        <= '0;
            remain_q      <= '0;
            res_angle_q   <= '0;
            res_cos_q     <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            core_angle_q  <= core_angle_d;
            step_q        <= step_d;
            remain_q      <= remain_d;
            res_angle_q   <= res_angle_d;
            res_cos_q     <= res_cos_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        core_angle_d  = core_angle_q;
        step_d        = step_q;
        remain_d      = remain_q;
        res_angle_d   = res_angle_q;
        res_cos_d     = res_cos_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    timeout_err_d = 1'b0;
                    if (count == 8'd0) begin
                        state_d = S_FIN;
                    end else begin
                        core_angle_d = angle_first;
                        step_d       = angle_step;
                        remain_d     = count;
                        cnt_d        = '0;
                        state_d      = S_ARM;
                    end
                end
            end
            S_ARM: begin
                // A ready still high from the previous conversion is stale;
                // wait until the core acknowledges the new start by dropping it.
                if (!core_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else if (cnt_last) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (core_ready) begin
                    state_d = S_CAPT;
                end else if (cnt_last) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPT: begin
                res_cos_d   = core_cos;
                res_angle_d = core_angle_q;
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (res_ack) begin
                    remain_d = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        state_d = S_FIN;
                    end else begin
                        // Wraps modulo 2^W by construction of the W-bit add.
                        core_angle_d = core_angle_q + step_q;
                        cnt_d        = '0;
                        state_d      = S_ARM;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All outputs decode from registers only, so reset forces them low at once.
    assign core_start  = (state_q == S_ARM) || (state_q == S_WAIT);
    assign core_angle  = core_angle_q;
    assign res_valid   = (state_q == S_OUT);
    assign res_angle   = res_angle_q;
    assign res_cos     = res_cos_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign timeout_err = timeout_err_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_cos_sweep_driver.sv
// ---------------------------------------------------------------------------
// tb_cos_sweep_driver
//
// Drives sweeps into cos_sweep_driver with a behavioural cosine core that
// answers after a random latency, and checks each sweep's results against
// the arithmetic angle sequence first + i*step (mod 2^W).
// ---------------------------------------------------------------------------
module tb_cos_sweep_driver;

    localparam int W = 24;

    // ---------------- clock / reset ----------------
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         go = 1'b0;
    logic [W-1:0] angle_first = '0;
    logic [W-1:0] angle_step = '0;
    logic [7:0]   count = '0;
    logic         core_ready = 1'b0;
    logic [W-1:0] core_cos = '0;
    logic         res_ack = 1'b0;
    logic         core_start, res_valid, busy, done, timeout_err;
    logic [W-1:0] core_angle, res_angle, res_cos;
    logic [2:0]   state_dbg;

    always #5 clock = ~clock;

    cos_sweep_driver #(.W(W), .FXP_SHIFT(10), .TIMEOUT(32)) dut (
        .clock(clock), .reset(reset), .go(go),
        .angle_first(angle_first), .angle_step(angle_step), .count(count),
        .core_start(core_start), .core_angle(core_angle),
        .core_ready(core_ready), .core_cos(core_cos),
        .res_valid(res_valid), .res_angle(res_angle), .res_cos(res_cos),
        .res_ack(res_ack), .busy(busy), .done(done),
        .timeout_err(timeout_err), .state_dbg_o(state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- behavioural core ----------------
    // Drops ready on seeing a new start, raises it with a result after a
    // random latency, keeps a stale ready high while start is low.
    int core_lat_min = 0;
    int core_lat_max = 3;
    bit core_stuck = 1'b0;
    bit core_started = 1'b0;
    int core_lat_cnt = 0;

    function automatic logic [W-1:0] model_cos(input logic [W-1:0] a);
        logic [W-1:0] t;
        t = a * 24'd3 + 24'd1024;
        return t;
    endfunction

    always @(negedge clock) begin
        if (core_stuck) begin
            core_ready = 1'b1;
        end else if (!core_start) begin
            core_started = 1'b0;
        end else if (!core_started) begin
            core_ready   = 1'b0;
            core_started = 1'b1;
            core_lat_cnt = int'($urandom_range(core_lat_max, core_lat_min));
        end else if (core_lat_cnt > 0) begin
            core_lat_cnt = core_lat_cnt - 1;
        end else if (!core_ready) begin
            core_ready = 1'b1;
            core_cos   = model_cos(core_angle);
        end
    end

    // ---------------- sweep driver (observes, does not judge) ----------------
    logic [W-1:0] got_angle_q[$];
    logic [W-1:0] got_cos_q[$];
    logic [W-1:0] exp_q[$];
    int n_done, done_cycle, n_rise, n_fall, start_cycles;
    int n_unstable, n_angle_move, n_overlap;
    bit sweep_timed_out;

    task automatic step_cycle();
        @(negedge clock);
        #1;
    endtask

    task automatic run_sweep(input logic [W-1:0] first, input logic [W-1:0] step,
                             input logic [7:0] cnt, input int ack_min,
                             input int ack_max, input bit noise);
        bit prev_start = 1'b0;
        bit prev_valid = 1'b0;
        logic [W-1:0] prev_angle = '0;
        logic [W-1:0] held_a = '0;
        logic [W-1:0] held_c = '0;
        int hold = 0;
        got_angle_q.delete();
        got_cos_q.delete();
        n_done = 0; done_cycle = 0; n_rise = 0; n_fall = 0; start_cycles = 0;
        n_unstable = 0; n_angle_move = 0; n_overlap = 0;
        go = 1'b1; angle_first = first; angle_step = step; count = cnt;
        step_cycle();
        go = 1'b0;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            if (core_start && !prev_start) n_rise++;
            if (!core_start && prev_start) n_fall++;
            if (core_start) start_cycles++;
            if (core_start && prev_start && core_angle != prev_angle) n_angle_move++;
            if (core_start && res_valid) n_overlap++;
            if (done) begin
                n_done++;
                if (n_done == 1) done_cycle = cyc;
            end
            if (res_valid && !prev_valid) begin
                got_angle_q.push_back(res_angle);
                got_cos_q.push_back(res_cos);
                held_a = res_angle;
                held_c = res_cos;
                hold = int'($urandom_range(ack_max, ack_min));
            end
            if (res_valid && (res_angle != held_a || res_cos != held_c)) n_unstable++;
            if (res_valid) begin
                res_ack = (hold == 0);
                if (hold > 0) hold--;
            end else begin
                res_ack = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            end
            // Requests while busy must be ignored.
            if (noise && busy) begin
                go = 1'($urandom_range(1, 0));
                angle_first = W'($urandom);
                angle_step = W'($urandom);
                count = 8'($urandom);
            end else begin
                go = 1'b0;
            end
            prev_start = core_start;
            prev_valid = res_valid;
            prev_angle = core_angle;
            if (n_done > 0 && !done) break;
            step_cycle();
        end
        go = 1'b0;
        res_ack = 1'b0;
        sweep_timed_out = (n_done == 0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step_cycle();
        n_checks++;
        if ({core_start, res_valid, busy, done, timeout_err} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {core_start, res_valid, busy, done, timeout_err});
        end
        n_checks++;
        if ({core_angle, res_angle, res_cos} !== '0) begin
            n_errors++;
            $display("FAIL reset_data: got %h %h %h expected 0 0 0", core_angle, res_angle, res_cos);
        end
        reset = 1'b0;
        step_cycle();
    endtask

    task automatic test_single();
        run_sweep(24'd0, 24'd0, 8'd1, 0, 0, 1'b0);
        n_checks++;
        if (sweep_timed_out || got_angle_q.size() != 1) begin
            n_errors++;
            $display("FAIL single_count: got %0d results expected 1", got_angle_q.size());
        end else begin
            n_checks++;
            if (got_angle_q[0] !== 24'd0 || got_cos_q[0] !== 24'd1024) begin
                n_errors++;
                $display("FAIL single_value: got %0d/%0d expected 0/1024", got_angle_q[0], got_cos_q[0]);
            end
        end
        n_checks++;
        if (n_done != 1) begin
            n_errors++;
            $display("FAIL single_done: got %0d pulses expected 1", n_done);
        end
    endtask

    task automatic test_sequence();
        run_sweep(24'd512, 24'd256, 8'd3, 0, 2, 1'b0);
        n_checks++;
        if (got_angle_q.size() != 3) begin
            n_errors++;
            $display("FAIL seq_count: got %0d expected 3", got_angle_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got_angle_q[i] !== W'(512 + 256 * i) ||
                    got_cos_q[i] !== model_cos(W'(512 + 256 * i))) begin
                    n_errors++;
                    $display("FAIL seq_value[%0d]: got %0d/%0d expected %0d/%0d", i,
                             got_angle_q[i], got_cos_q[i], 512 + 256 * i, model_cos(W'(512 + 256 * i)));
                end
            end
        end
        n_checks++;
        if (n_rise != 3 || n_fall != 3 || n_done != 1 || n_angle_move != 0) begin
            n_errors++;
            $display("FAIL seq_handshake: got rise=%0d fall=%0d done=%0d move=%0d expected 3 3 1 0",
                     n_rise, n_fall, n_done, n_angle_move);
        end
    endtask

    task automatic test_count_zero();
        run_sweep(24'h123, 24'h7, 8'd0, 0, 0, 1'b0);
        n_checks++;
        if (n_done != 1 || done_cycle > 2 || n_rise != 0 || got_angle_q.size() != 0) begin
            n_errors++;
            $display("FAIL count_zero: got done=%0d at %0d starts=%0d res=%0d expected 1 at <=2, 0, 0",
                     n_done, done_cycle, n_rise, got_angle_q.size());
        end
    endtask

    task automatic test_ack_hold();
        run_sweep(24'd40, 24'hFFFFF0, 8'd2, 10, 10, 1'b0);
        n_checks++;
        if (n_unstable != 0 || n_overlap != 0 || n_rise != 2) begin
            n_errors++;
            $display("FAIL ack_hold: got unstable=%0d overlap=%0d starts=%0d expected 0 0 2",
                     n_unstable, n_overlap, n_rise);
        end
        n_checks++;
        if (got_angle_q.size() != 2 || got_angle_q[1] !== 24'd24) begin
            n_errors++;
            $display("FAIL ack_hold_value: got size %0d expected second angle 24", got_angle_q.size());
        end
    endtask

    task automatic test_random();
        logic [W-1:0] first, step;
        logic [7:0] cnt;
        int bad;
        for (int t = 0; t < 6; t++) begin
            first = W'($urandom);
            step = W'($urandom);
            cnt = 8'($urandom_range(6, 1));
            core_lat_max = 4;
            exp_q.delete();
            for (int i = 0; i < int'(cnt); i++) exp_q.push_back(W'(first + W'(i) * step));
            run_sweep(first, step, cnt, 0, 4, 1'b1);
            bad = 0;
            if (got_angle_q.size() != exp_q.size()) bad = 1;
            else
                for (int i = 0; i < exp_q.size(); i++)
                    if (got_angle_q[i] !== exp_q[i] || got_cos_q[i] !== model_cos(exp_q[i])) bad = 1;
            n_checks++;
            if (bad != 0) begin
                n_errors++;
                $display("FAIL random_seq[%0d]: got %0d results expected %0d (first=%h step=%h)",
                         t, got_angle_q.size(), exp_q.size(), first, step);
            end
            n_checks++;
            if (n_done != 1 || n_unstable != 0 || n_overlap != 0 || timeout_err !== 1'b0) begin
                n_errors++;
                $display("FAIL random_ctrl[%0d]: got done=%0d unstable=%0d overlap=%0d err=%b expected 1 0 0 0",
                         t, n_done, n_unstable, n_overlap, timeout_err);
            end
        end
    endtask

    task automatic test_timeout();
        core_stuck = 1'b1;
        run_sweep(24'd100, 24'd1, 8'd2, 0, 0, 1'b0);
        step_cycle();
        n_checks++;
        if (start_cycles != 32 || got_angle_q.size() != 0 || n_done != 1) begin
            n_errors++;
            $display("FAIL timeout_arm: got start_cycles=%0d res=%0d done=%0d expected 32 0 1",
                     start_cycles, got_angle_q.size(), n_done);
        end
        n_checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || core_start !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_flags: got err=%b busy=%b start=%b expected 1 0 0",
                     timeout_err, busy, core_start);
        end
        core_stuck = 1'b0;
        run_sweep(24'd7, 24'd5, 8'd1, 0, 1, 1'b0);
        n_checks++;
        if (timeout_err !== 1'b0 || got_angle_q.size() != 1) begin
            n_errors++;
            $display("FAIL timeout_clear: got err=%b res=%0d expected 0 1", timeout_err, got_angle_q.size());
        end
    endtask

    task automatic test_wrap_reset();
        int k = 0;
        bit hit = 1'b0;
        run_sweep(24'h7FFFFF, 24'd1, 8'd2, 0, 1, 1'b0);
        n_checks++;
        if (got_angle_q.size() != 2 || got_angle_q[1] !== 24'h800000 ||
            got_cos_q[1] !== model_cos(24'h800000)) begin
            n_errors++;
            $display("FAIL wrap_angle: got size %0d expected second angle 800000", got_angle_q.size());
        end
        // Second run: reset while the core works on the wrapped angle.
        core_lat_min = 8; core_lat_max = 8;
        go = 1'b1; angle_first = 24'h7FFFFF; angle_step = 24'd1; count = 8'd2;
        step_cycle();
        go = 1'b0;
        for (int cyc = 0; cyc < 300 && !hit; cyc++) begin
            res_ack = res_valid;
            if (core_start && core_angle == 24'h800000) k++;
            if (k == 4) hit = 1'b1;
            else step_cycle();
        end
        res_ack = 1'b0;
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL wrap_reach_wait: got no second conversion expected one within 300 cycles");
        end
        reset = 1'b1;
        step_cycle();
        n_checks++;
        if ({core_start, res_valid, busy, done, timeout_err} !== 5'b0 ||
            {core_angle, res_angle, res_cos} !== '0) begin
            n_errors++;
            $display("FAIL wrap_reset_outputs: got ctrl=%b data=%h/%h/%h expected all 0",
                     {core_start, res_valid, busy, done, timeout_err}, core_angle, res_angle, res_cos);
        end
        reset = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            step_cycle();
            if (done || core_start || busy) k++;
        end
        n_checks++;
        if (k != 0) begin
            n_errors++;
            $display("FAIL wrap_reset_quiet: got %0d active cycles expected 0", k);
        end
        core_lat_min = 0; core_lat_max = 3;
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_count_zero();
        test_ack_hold();
        test_random();
        test_timeout();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cos_sweep_driver.md
COS_SWEEP_DRIVER -- requirements
Module: cos_sweep_driver

Interface
REQ-001 Parameter W, default 24: data width of angles and results, signed fixed point.
REQ-002 Parameter FXP_SHIFT, default 10: fractional bits, Q(W-10).10; 1.0 = 1024.
REQ-003 Parameter TIMEOUT, default 32: maximum cycles to wait for each core ready transition.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 go  in  1  sweep request, sampled in IDLE only.
REQ-007 angle_first  in  W  first angle of sweep, sampled with go.
REQ-008 angle_step  in  W  signed angle increment, sampled with go.
REQ-009 count  in  8  number of angles in sweep, sampled with go.
REQ-010 core_start  out  1  start request to cosine core.
REQ-011 core_angle  out  W  angle presented to cosine core.
REQ-012 core_ready  in  1  cosine core result-ready flag.
REQ-013 core_cos  in  W  cosine core result.
REQ-014 res_valid  out  1  result available.
REQ-015 res_angle  out  W  angle belonging to current result.
REQ-016 res_cos  out  W  captured cosine result.
REQ-017 res_ack  in  1  consumer accepts result.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle pulse at sweep end, normal or aborted.
REQ-020 timeout_err  out  1  sticky error flag, cleared by reset or accepted go.

Function
REQ-021 FSM states: IDLE, ARM, WAIT, CAPT, OUT, FIN. All transitions are on the rising clock edge.
REQ-022 IDLE: if go=1 and count=0, go to FIN with no core_start; if go=1 and count>0, latch inputs, set core_angle=angle_first, clear timeout_err, go to ARM.
REQ-023 ARM: core_start=1; wait for core_ready=0 (stale ready from the previous conversion is not a result), then go to WAIT.
REQ-024 WAIT: core_start=1; on core_ready=1 go to CAPT.
REQ-025 CAPT: core_start=0; res_cos<=core_cos, res_angle<=core_angle; go to OUT next cycle.
REQ-026 OUT: res_valid=1; res_cos and res_angle hold stable until res_ack=1.
REQ-027 On res_valid&res_ack: decrement remaining count; if zero go to FIN, else core_angle<=core_angle+angle_step and go to ARM.
REQ-028 OUT->ARM: ARM is entered no earlier than one cycle after core_start=0, so the core sees start low and returns to its idle state.
REQ-029 res_ack while res_valid=0 is ignored.
REQ-030 FIN: done=1 for exactly one cycle, then go to IDLE.
REQ-031 core_angle changes only in IDLE (on accepted go) and on the OUT->ARM transition; it is stable through ARM, WAIT and CAPT.
REQ-032 Angle add wraps modulo 2^W; there is no saturation.
REQ-033 A per-phase cycle counter resets on entry to ARM and on entry to WAIT.
REQ-034 If the counter reaches TIMEOUT in ARM or WAIT: set timeout_err=1, drop core_start, go to FIN; no result is emitted for that angle.
REQ-035 go is ignored while busy=1.
REQ-036 One result per angle, emitted in sweep order; throughput is limited by the core and by res_ack only.

Reset
REQ-037 While reset=1: state=IDLE; core_start, res_valid, busy, done and timeout_err are 0; core_angle, res_angle and res_cos are 0; counters are 0.
REQ-038 Reset mid-sweep aborts immediately with no done pulse and no further core_start.
REQ-039 reset has priority over every other input in the same cycle.

Verification
REQ-040 angle_first=0, step=0, count=1, core model returns 1024 -> one res_valid with res_angle=0, res_cos=1024, then one done pulse.
REQ-041 angle_first=512, step=256, count=3 -> res_angle sequence 512, 768, 1024; core_start falls between conversions; done pulses once.
REQ-042 count=0 with go -> done pulses 2 cycles after go; core_start never asserts.
REQ-043 core_ready held 1 permanently -> stuck in ARM; after 32 cycles timeout_err=1, done pulses, busy=0.
REQ-044 res_ack withheld 10 cycles -> res_valid and res_cos stable for all 10 cycles; next angle is not issued before the ack.
REQ-045 angle_first=0x7FFFFF, step=1, count=2 -> second res_angle=0x800000 (wrap); reset asserted during the second WAIT -> all outputs 0 next cycle.
